doodle_jump_fsm: RTL and testbench

Parametrised jump/fall controller for the doodle character, the next generation of the single-purpose doodle state machine. It owns the jump counter internally, advances only on a per-frame `Tick`, and tests collision against a runtime-supplied table of `NUM_PLAT` platforms instead of fixed coordinates. It keeps a saturating score, can optionally drive a scroll offset, and sits between the VGA timing/frame-tick logic and the renderer.

---
 rtl/doodle_pkg.sv | 21 ++
 rtl/doodle_jump_fsm_if.sv | 42 ++++
 rtl/doodle_plat_hit.sv | 55 +++++
 rtl/doodle_jump_fsm.sv | 141 ++++++++++++++
 tb/tb_doodle_jump_fsm.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/doodle_pkg.sv
// Shared types and constants for the doodle jump/fall controller: one-hot state
// encodings, default geometry and VGA-relative screen rows.
package doodle_pkg;

  typedef enum logic [3:0] {
    ST_I    = 4'b0001,
    ST_UP   = 4'b0010,
    ST_DOWN = 4'b0100,
    ST_DONE = 4'b1000
  } state_e;

  localparam int DEF_DOODLE_R = 10;
  localparam int DEF_PLAT_W   = 64;
  localparam int DEF_PLAT_T   = 10;

  localparam int H_OFFSET = 144;
  localparam int V_OFFSET = 35;
  localparam int Y_BOTTOM = V_OFFSET + 480;
  localparam int V_MIDDLE = V_OFFSET + 240;

endpackage

// File: rtl/doodle_jump_fsm_if.sv
// Control/data bundle between the frame logic, the platform table and the
// doodle controller; master drives game inputs, slave is the controller.
interface doodle_jump_fsm_if #(
  parameter int NUM_PLAT = 12,
  parameter int XW       = 10,
  parameter int YW       = 10,
  parameter int SCORE_W  = 16
) ();

  localparam int IW = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;

  logic                   Start;
  logic                   Ack;
  logic                   Tick;
  logic [YW-1:0]          jump_height;
  logic [XW-1:0]          obj_x;
  logic [YW-1:0]          obj_y;
  logic [NUM_PLAT*XW-1:0] plat_x;
  logic [NUM_PLAT*YW-1:0] plat_y;
  logic [NUM_PLAT-1:0]    plat_valid;

  logic                   q_I;
  logic                   q_Up;
  logic                   q_Down;
  logic                   q_Done;
  logic [YW-1:0]          up_count;
  logic [SCORE_W-1:0]     score;
  logic [IW-1:0]          hit_idx;
  logic                   jump_pulse;
  logic [YW-1:0]          scroll_offset;

  modport master (
    output Start, Ack, Tick, jump_height, obj_x, obj_y, plat_x, plat_y, plat_valid,
    input  q_I, q_Up, q_Down, q_Done, up_count, score, hit_idx, jump_pulse, scroll_offset
  );

  modport slave (
    input  Start, Ack, Tick, jump_height, obj_x, obj_y, plat_x, plat_y, plat_valid,
    output q_I, q_Up, q_Down, q_Done, up_count, score, hit_idx, jump_pulse, scroll_offset
  );

endinterface

// File: rtl/doodle_plat_hit.sv
// Combinational landing test of the doodle foot point against every platform
// slot, with a lowest-index-wins priority encoder.
module doodle_plat_hit
  import doodle_pkg::*;
#(
  parameter int NUM_PLAT = 12,
  parameter int XW       = 10,
  parameter int YW       = 10,
  parameter int DOODLE_R = DEF_DOODLE_R,
  parameter int PLAT_W   = DEF_PLAT_W,
  parameter int PLAT_T   = DEF_PLAT_T,
  parameter int IW       = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1
) (
  input  logic [XW-1:0]          obj_x,
  input  logic [YW-1:0]          obj_y,
  input  logic [NUM_PLAT*XW-1:0] plat_x,
  input  logic [NUM_PLAT*YW-1:0] plat_y,
  input  logic [NUM_PLAT-1:0]    plat_valid,
  output logic                   hit,
  output logic [IW-1:0]          idx
);

  logic [XW:0]         fx;
  logic [YW:0]         fy;
  logic [NUM_PLAT-1:0] hit_vec;

  // Every sum is one bit wider than its operands so no bound can wrap.
  assign fx = {1'b0, obj_x} + (XW+1)'(DOODLE_R);
  assign fy = {1'b0, obj_y} + (YW+1)'(DOODLE_R);

  always_comb begin
    logic [XW:0] x_lo, x_hi;
    logic [YW:0] y_lo, y_hi;
    hit_vec = '0;
    for (int i = 0; i < NUM_PLAT; i++) begin
      x_lo = {1'b0, plat_x[i*XW +: XW]};
      x_hi = x_lo + (XW+1)'(PLAT_W);
      y_lo = {1'b0, plat_y[i*YW +: YW]};
      y_hi = y_lo + (YW+1)'(PLAT_T);
      hit_vec[i] = plat_valid[i] && (fx >= x_lo) && (fx <= x_hi) &&
                   (fy >= y_lo) && (fy <= y_hi);
    end
  end

  // Scanning from the top down leaves the lowest hitting index as the winner.
  always_comb begin
    idx = '0;
    for (int i = NUM_PLAT - 1; i >= 0; i--) begin
      if (hit_vec[i]) idx = IW'(i);
    end
  end

  assign hit = |hit_vec;

endmodule

// File: rtl/doodle_jump_fsm.sv
// Tick-driven jump/fall controller for the doodle with runtime platform table,
// saturating score and optional scroll offset (enabled by DOODLE_SCROLL_EN).
module doodle_jump_fsm
  import doodle_pkg::*;
#(
  parameter int NUM_PLAT = 12,
  parameter int XW       = 10,
  parameter int YW       = 10,
  parameter int SCORE_W  = 16,
  parameter int DOODLE_R = DEF_DOODLE_R,
  parameter int PLAT_W   = DEF_PLAT_W,
  parameter int PLAT_T   = DEF_PLAT_T,
  parameter int Y_BOTTOM = doodle_pkg::Y_BOTTOM,
  parameter int V_MIDDLE = doodle_pkg::V_MIDDLE
) (
  input logic              Clk,
  input logic              Reset_n,
  doodle_jump_fsm_if.slave bus
);

  localparam int IW = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;

  state_e             state_q, state_d;
  logic [YW-1:0]      up_count_q, up_count_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [IW-1:0]      hit_idx_q, hit_idx_d;
  logic               jump_pulse_q, jump_pulse_d;
  logic [YW-1:0]      scroll_q, scroll_d;

  logic               plat_hit;
  logic [IW-1:0]      plat_idx;
  logic [YW:0]        fy;

  doodle_plat_hit #(
    .NUM_PLAT (NUM_PLAT),
    .XW       (XW),
    .YW       (YW),
    .DOODLE_R (DOODLE_R),
    .PLAT_W   (PLAT_W),
    .PLAT_T   (PLAT_T),
    .IW       (IW)
  ) u_plat_hit (
    .obj_x      (bus.obj_x),
    .obj_y      (bus.obj_y),
    .plat_x     (bus.plat_x),
    .plat_y     (bus.plat_y),
    .plat_valid (bus.plat_valid),
    .hit        (plat_hit),
    .idx        (plat_idx)
  );

  assign fy = {1'b0, bus.obj_y} + (YW+1)'(DOODLE_R);

  // NOTE: every _d gets a hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    up_count_d   = up_count_q;
    score_d      = score_q;
    hit_idx_d    = hit_idx_q;
    jump_pulse_d = 1'b0;
    scroll_d     = scroll_q;

    case (state_q)
      ST_I: begin
        up_count_d = '0;
        score_d    = '0;
        scroll_d   = '0;
        if (bus.Start) state_d = ST_UP;
      end
      ST_UP: begin
        if (bus.Tick) begin
          if (up_count_q >= bus.jump_height) begin
            state_d = ST_DOWN;
          end else begin
            up_count_d = up_count_q + 1'b1;
            if (score_q != '1) score_d = score_q + 1'b1;
          end
`ifdef DOODLE_SCROLL_EN
          if ((bus.obj_y < YW'(V_MIDDLE)) && (scroll_q != '1)) scroll_d = scroll_q + 1'b1;
`endif
        end
      end
      ST_DOWN: begin
        if (bus.Tick) begin
          if (plat_hit) begin
            state_d      = ST_UP;
            up_count_d   = '0;
            hit_idx_d    = plat_idx;
            jump_pulse_d = 1'b1;
          end else if (fy > (YW+1)'(Y_BOTTOM)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // Clearing on the way out keeps score at 0 from the first cycle in I.
        if (bus.Ack) begin
          state_d    = ST_I;
          up_count_d = '0;
          score_d    = '0;
          scroll_d   = '0;
        end
      end
      default: state_d = ST_I;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_I;
      up_count_q   <= '0;
      score_q      <= '0;
      hit_idx_q    <= '0;
      jump_pulse_q <= 1'b0;
      scroll_q     <= '0;
    end else begin
      state_q      <= state_d;
      up_count_q   <= up_count_d;
      score_q      <= score_d;
      hit_idx_q    <= hit_idx_d;
      jump_pulse_q <= jump_pulse_d;
      scroll_q     <= scroll_d;
    end
  end

  assign bus.q_I        = state_q[0];
  assign bus.q_Up       = state_q[1];
  assign bus.q_Down     = state_q[2];
  assign bus.q_Done     = state_q[3];
  assign bus.up_count   = up_count_q;
  assign bus.score      = score_q;
  assign bus.hit_idx    = hit_idx_q;
  assign bus.jump_pulse = jump_pulse_q;
`ifdef DOODLE_SCROLL_EN
  assign bus.scroll_offset = scroll_q;
`else
  assign bus.scroll_offset = '0;
`endif

endmodule

// File: tb/tb_doodle_jump_fsm.sv
// Directed bench for doodle_jump_fsm: jump/fall sequencing, collision priority,
// bottom/game-over, Start/Ack filtering, score saturation, scroll and async reset.
module tb_doodle_jump_fsm;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  doodle_jump_fsm_if #(.NUM_PLAT(12), .XW(10), .YW(10), .SCORE_W(16)) m_if ();
  doodle_jump_fsm_if #(.NUM_PLAT(12), .XW(10), .YW(10), .SCORE_W(4))  s_if ();

  doodle_jump_fsm #(.SCORE_W(16)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(m_if.slave));
  doodle_jump_fsm #(.SCORE_W(4))  dut_sat (.Clk(Clk), .Reset_n(Reset_n), .bus(s_if.slave));

  int n_total = 0;
  int n_bad   = 0;

`ifdef DOODLE_SCROLL_EN
  localparam int EXP_SCROLL = 4;
`else
  localparam int EXP_SCROLL = 0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick();
    m_if.Tick = 1'b1;
    s_if.Tick = 1'b1;
    step();
    m_if.Tick = 1'b0;
    s_if.Tick = 1'b0;
  endtask

  task automatic set_plat(input int i, input int x, input int y, input logic v);
    m_if.plat_x[i*10 +: 10] = 10'(x);
    m_if.plat_y[i*10 +: 10] = 10'(y);
    m_if.plat_valid[i]      = v;
  endtask

  task automatic check_state(input string tag, input logic [3:0] exp_ohot);
    check({tag, ".state"}, {28'd0, m_if.q_Done, m_if.q_Down, m_if.q_Up, m_if.q_I},
          {28'd0, exp_ohot});
  endtask

  initial begin
    m_if.Start = 0; m_if.Ack = 0; m_if.Tick = 0; m_if.jump_height = 10'd5;
    m_if.obj_x = 10'd300; m_if.obj_y = 10'd280;
    m_if.plat_x = '0; m_if.plat_y = '0; m_if.plat_valid = '0;
    s_if.Start = 0; s_if.Ack = 0; s_if.Tick = 0; s_if.jump_height = 10'd20;
    s_if.obj_x = '0; s_if.obj_y = 10'd400;
    s_if.plat_x = '0; s_if.plat_y = '0; s_if.plat_valid = '0;

    step(); step();
    check_state("reset", 4'b0001);
    check("reset.score", 32'(m_if.score), 0);
    check("reset.up_count", 32'(m_if.up_count), 0);
    check("reset.hit_idx", 32'(m_if.hit_idx), 0);
    check("reset.jump_pulse", 32'(m_if.jump_pulse), 0);
    check("reset.scroll", 32'(m_if.scroll_offset), 0);
    Reset_n = 1'b1;
    step();
    check_state("idle_no_start", 4'b0001);

    // Start without Tick enters UP.
    m_if.Start = 1; step(); m_if.Start = 0;
    check_state("start", 4'b0010);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("up%0d.up_count", k), 32'(m_if.up_count), 32'(k));
      check($sformatf("up%0d.score", k), 32'(m_if.score), 32'(k));
    end
    check_state("up5", 4'b0010);
    tick();
    check_state("tick6_down", 4'b0100);
    check("tick6.score", 32'(m_if.score), 5);

    // Landing on slot 3: fx=310 in [256,320], fy=290 in [285,295].
    set_plat(3, 256, 285, 1'b1);
    step();
    check_state("down_no_tick", 4'b0100);
    tick();
    check_state("land3", 4'b0010);
    check("land3.hit_idx", 32'(m_if.hit_idx), 3);
    check("land3.pulse", 32'(m_if.jump_pulse), 1);
    check("land3.up_count", 32'(m_if.up_count), 0);
    step();
    check("land3.pulse_off", 32'(m_if.jump_pulse), 0);
    check("land3.scroll_hi_obj", 32'(m_if.scroll_offset), 0);

    for (int k = 0; k < 6; k++) tick();
    check_state("rejump_down", 4'b0100);
    check("rejump.score", 32'(m_if.score), 10);

    set_plat(3, 0, 0, 1'b0);
    set_plat(2, 256, 285, 1'b1);
    set_plat(5, 256, 285, 1'b1);
    tick();
    check("prio.hit_idx", 32'(m_if.hit_idx), 2);

    for (int k = 0; k < 6; k++) tick();
    m_if.plat_valid[2] = 1'b0;
    tick();
    check_state("prio5", 4'b0010);
    check("prio5.hit_idx", 32'(m_if.hit_idx), 5);

    for (int k = 0; k < 6; k++) tick();
    check("fall.score", 32'(m_if.score), 20);
    m_if.plat_valid = '0;
    m_if.obj_y = 10'd505;            // fy = 515, not below the bottom
    tick();
    check_state("bottom_edge", 4'b0100);
    m_if.obj_y = 10'd506;            // fy = 516
    tick();
    check_state("game_over", 4'b1000);
    tick();
    check("done.score_frozen", 32'(m_if.score), 20);
    m_if.Start = 1; step();
    check_state("done_ignore_start", 4'b1000);
    m_if.Ack = 1; step();             // Start and Ack together: Ack acts in DONE
    m_if.Start = 0; m_if.Ack = 0;
    check_state("ack", 4'b0001);
    check("ack.score", 32'(m_if.score), 0);
    step();
    check_state("idle_after_ack", 4'b0001);

    // Zero-length jump drops straight to DOWN with no score.
    m_if.jump_height = 10'd0;
    m_if.obj_y = 10'd280;
    m_if.Start = 1; step(); m_if.Start = 0;
    tick();
    check_state("jh0", 4'b0100);
    check("jh0.score", 32'(m_if.score), 0);
    m_if.Ack = 1; step(); m_if.Ack = 0;
    check_state("down_ignore_ack", 4'b0100);
    m_if.obj_y = 10'd506;
    tick();
    m_if.Ack = 1; step(); m_if.Ack = 0;
    check_state("back_to_idle", 4'b0001);

    // Scroll while above the middle row, then reset mid-UP.
    m_if.jump_height = 10'd10;
    m_if.obj_y = 10'd200;
    m_if.Start = 1; step(); m_if.Start = 0;
    for (int k = 0; k < 4; k++) tick();
    check("scroll.offset", 32'(m_if.scroll_offset), 32'(EXP_SCROLL));
    check("scroll.score", 32'(m_if.score), 4);
    Reset_n = 1'b0;
    #2;
    check_state("async_rst", 4'b0001);
    check("async_rst.score", 32'(m_if.score), 0);
    check("async_rst.up_count", 32'(m_if.up_count), 0);
    check("async_rst.hit_idx", 32'(m_if.hit_idx), 0);
    check("async_rst.scroll", 32'(m_if.scroll_offset), 0);
    check("async_rst.pulse", 32'(m_if.jump_pulse), 0);
    step();
    Reset_n = 1'b1;
    step();

    // 4-bit score saturates at 15 over a 20-tick jump.
    s_if.Start = 1; step(); s_if.Start = 0;
    for (int k = 0; k < 20; k++) tick();
    check("sat.score", 32'(s_if.score), 15);
    check("sat.up_count", 32'(s_if.up_count), 20);
    check("sat.state_up", 32'(s_if.q_Up), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
